prio_readout_ctrl: RTL

Sequencer and fixed-priority arbiter for a bank of N memory readout units. Each unit is a per-memory item counter with init/setup/sel inputs and registered has_dat/valid outputs. On each crossing start, the block loads all units, holds setup, then grants sel to one unit at a time, lowest index first, until every unit is drained or a cycle budget expires. It also provides the memory index aligned with each unit's registered valid, so downstream logic can build {idx, addr}.

---
 rtl/prio_readout_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/prio_readout_ctrl.sv
// Readout sequencer: pulse init, hold setup, then grant sel one unit at a time, lowest index first.
// All outputs registered; start in any state restarts the crossing, budget expiry truncates it.
module prio_readout_ctrl #(
  parameter int N            = 8,
  parameter int IDXW         = 3,
  parameter int SETUP_CYCLES = 2,
  parameter int MAX_CYCLES   = 64,
  parameter int CNTW         = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N-1:0]    has_dat,
  output logic            init_o,
  output logic            setup_o,
  output logic [N-1:0]    sel,
  output logic [IDXW-1:0] rd_idx,
  output logic            busy,
  output logic            done,
  output logic            truncated
);

  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam logic [SW-1:0]   SETUP_LAST  = SW'(SETUP_CYCLES - 1);
  localparam logic [CNTW-1:0] BUDGET_LAST = (MAX_CYCLES == 0) ? '0 : CNTW'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, INIT, SETUP, READ} state_t;

  state_t          state_q, state_d;
  logic            init_q, init_d;
  logic            setup_q, setup_d;
  logic [N-1:0]    sel_q, sel_d;
  logic [IDXW-1:0] rd_idx_q, rd_idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            trunc_q, trunc_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [CNTW-1:0] bcnt_q, bcnt_d;
  logic            arb;

  // Two's-complement trick isolates the lowest set request bit.
  function automatic logic [N-1:0] pick_lowest(input logic [N-1:0] req);
    return req & (~req + N'(1));
  endfunction

  function automatic logic [IDXW-1:0] encode(input logic [N-1:0] oh);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) r = r | IDXW'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    trunc_d  = trunc_q;
    scnt_d   = scnt_q;
    bcnt_d   = bcnt_q;
    arb      = 1'b0;
    rd_idx_d = (|sel_q) ? encode(sel_q) : rd_idx_q;

    if (start) begin
      state_d = INIT;
      sel_d   = '0;
      trunc_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        INIT: begin
          state_d = SETUP;
          scnt_d  = SETUP_LAST;
        end
        SETUP: begin
          if (scnt_q == '0) begin
            bcnt_d = '0;
            arb    = 1'b1;
          end else begin
            scnt_d = scnt_q - SW'(1);
          end
        end
        READ: begin
          // Budget expiry wins over a grant that happens to finish on the same edge.
          if (MAX_CYCLES != 0 && bcnt_q == BUDGET_LAST) begin
            sel_d   = '0;
            done_d  = 1'b1;
            trunc_d = 1'b1;
            state_d = IDLE;
          end else begin
            bcnt_d = bcnt_q + CNTW'(1);
            arb    = ~|(has_dat & sel_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (arb) begin
      sel_d = pick_lowest(has_dat);
      if (has_dat == '0) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = READ;
      end
    end

    init_d  = (state_d == INIT);
    setup_d = (state_d == INIT) || (state_d == SETUP);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      init_q   <= 1'b0;
      setup_q  <= 1'b0;
      sel_q    <= '0;
      rd_idx_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      trunc_q  <= 1'b0;
      scnt_q   <= '0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      setup_q  <= setup_d;
      sel_q    <= sel_d;
      rd_idx_q <= rd_idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      trunc_q  <= trunc_d;
      scnt_q   <= scnt_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign init_o    = init_q;
  assign setup_o   = setup_q;
  assign sel       = sel_q;
  assign rd_idx    = rd_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign truncated = trunc_q;

endmodule
